// File: rtl/core_regfile_wbarb_pkg.sv
// Shared core constants and types for the register-file write-port scheduler.
package core_regfile_wbarb_pkg;

  // Data and register-address geometry of the core.
  localparam int XLEN       = 32;
  localparam int XL         = XLEN - 1;
  localparam int REG_ADDR_R = 4;
  localparam int REG_ADDR_W = REG_ADDR_R + 1;
  localparam int NREGS      = 1 << REG_ADDR_W;

  // Hard-wired zero register; never written, never pending.
  localparam logic [REG_ADDR_R:0] X0 = '0;

  // Default starvation policy; the core top may override both.
  // STARVE_W must be wide enough that 2**STARVE_W > STARVE_LIMIT.
  localparam int DEF_STARVE_LIMIT = 3;
  localparam int DEF_STARVE_W     = 2;

  // Which source owns the write port this cycle.
  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_A    = 2'd1,
    SRC_B    = 2'd2
  } wb_src_e;

  // One writeback request as seen by the write port.
  typedef struct packed {
    logic [REG_ADDR_R:0] rd;
    logic [XL:0]         wdata;
  } wb_req_t;

  function automatic logic is_x0(input logic [REG_ADDR_R:0] r);
    return r == X0;
  endfunction

endpackage

// File: rtl/core_regfile_sb.sv
// Pending-destination scoreboard for long-latency results, with a 3-way
// hazard lookup for the issuing instruction's rs1/rs2/rd.
module core_regfile_sb
  import core_regfile_wbarb_pkg::*;
(
  input  logic                g_clk,
  input  logic                g_resetn,
  input  logic                set_en,
  input  logic [REG_ADDR_R:0] set_rd,
  input  logic                clr_en,
  input  logic [REG_ADDR_R:0] clr_rd,
  input  logic [REG_ADDR_R:0] q_rs1,
  input  logic [REG_ADDR_R:0] q_rs2,
  input  logic [REG_ADDR_R:0] q_rd,
  output logic                sb_hit
);

  // One pending bit per architectural register except x0.
  logic [NREGS-1:1] pend_q;
  logic [NREGS-1:1] set_mask;
  logic [NREGS-1:1] clr_mask;
  logic [NREGS-1:0] pend_full;

  // Decode the set and clear requests into one-hot masks.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    set_mask = '0;
    clr_mask = '0;
    for (int i = 1; i < NREGS; i++) begin
      set_mask[i] = set_en && (set_rd == REG_ADDR_W'(i));
      clr_mask[i] = clr_en && (clr_rd == REG_ADDR_W'(i));
    end
  end

  // Pending bits: a set in the same cycle as a clear of the same register wins.
  always_ff @(posedge g_clk or negedge g_resetn) begin
    // NOTE: the scoreboard is ordinary flops, not RAM, so it is reset like any other state.
    if (!g_resetn) begin
      pend_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
      pend_q <= (pend_q & ~clr_mask) | set_mask;
    end
  end

  // x0 maps to a constant-zero bit, so it never reports a hazard.
  assign pend_full = {pend_q, 1'b0};
  assign sb_hit    = pend_full[q_rs1] | pend_full[q_rs2] | pend_full[q_rd];

endmodule

// File: rtl/core_regfile_wbarb.sv
// Write-port scheduler for the 2R/1W register file: arbitrates pipeline
// writeback (A) against long-latency results (B) with starvation relief,
// registers the winning write, and reports issue hazards.
module core_regfile_wbarb
  import core_regfile_wbarb_pkg::*;
#(
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT,
  parameter int STARVE_W     = DEF_STARVE_W
) (
  input  logic                g_clk,
  input  logic                g_resetn,
  input  logic                a_valid,
  output logic                a_ready,
  input  logic [REG_ADDR_R:0] a_rd,
  input  logic [XL:0]         a_wdata,
  input  logic                b_valid,
  output logic                b_ready,
  input  logic [REG_ADDR_R:0] b_rd,
  input  logic [XL:0]         b_wdata,
  input  logic                sb_set,
  input  logic [REG_ADDR_R:0] sb_rd,
  input  logic [REG_ADDR_R:0] q_rs1,
  input  logic [REG_ADDR_R:0] q_rs2,
  input  logic [REG_ADDR_R:0] q_rd,
  output logic                q_hazard,
  output logic                rf_wen,
  output logic [REG_ADDR_R:0] rf_addr,
  output logic [XL:0]         rf_wdata
);

  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

  logic [STARVE_W-1:0] cnt_q;
  logic                starved;
  wb_src_e             win;
  wb_req_t             win_req;
  logic                sb_hit;

  // Arbitration: A normally wins; once B has waited STARVE_LIMIT cycles, B wins.
  always_comb begin
    starved = (cnt_q == STARVE_MAX);
    a_ready = 1'b1;
    b_ready = !a_valid;
    win     = SRC_NONE;
    win_req = '0;
    if (starved) begin
      b_ready = 1'b1;
      a_ready = !b_valid;
    end
    if (a_valid && a_ready) begin
      win     = SRC_A;
      win_req = '{rd: a_rd, wdata: a_wdata};
    end else if (b_valid && b_ready) begin
      win     = SRC_B;
      win_req = '{rd: b_rd, wdata: b_wdata};
    end
  end

  // Starvation counter: counts consecutive cycles B is held off, saturating.
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      cnt_q <= '0;
    end else if (b_valid && !b_ready) begin
      cnt_q <= starved ? cnt_q : cnt_q + STARVE_W'(1);
    end else begin
      cnt_q <= '0;
    end
  end

  // Output stage: register the winner; writes to x0 complete but never enable.
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      rf_wen   <= 1'b0;
      rf_addr  <= '0;
      rf_wdata <= '0;
    end else begin
      rf_wen <= (win != SRC_NONE) && !is_x0(win_req.rd);
      if (win != SRC_NONE) begin
        rf_addr  <= win_req.rd;
        rf_wdata <= win_req.wdata;
      end
    end
  end

  core_regfile_sb u_sb (
    .g_clk    (g_clk),
    .g_resetn (g_resetn),
    .set_en   (sb_set),
    .set_rd   (sb_rd),
    .clr_en   (win == SRC_B),
    .clr_rd   (b_rd),
    .q_rs1    (q_rs1),
    .q_rs2    (q_rs2),
    .q_rd     (q_rd),
    .sb_hit   (sb_hit)
  );

  // The registered write is not visible to readers until the edge after it, and
  // there is no bypass, so a source matching it must stall. Only flops and q_*
  // feed this, keeping a_valid/b_valid out of the issue-stall path.
  assign q_hazard = sb_hit ||
                    (rf_wen && !is_x0(rf_addr) && (rf_addr == q_rs1 || rf_addr == q_rs2));

endmodule

// File: tb/tb_core_regfile_wbarb.sv
// Self-checking bench for core_regfile_wbarb: directed steps plus a random
// phase, all compared against a behavioural model of the write-port rules.
module tb_core_regfile_wbarb;
  import core_regfile_wbarb_pkg::*;

  localparam int LIMIT = 3;

  logic                g_clk;
  logic                g_resetn;
  logic                a_valid, a_ready;
  logic [REG_ADDR_R:0] a_rd;
  logic [XL:0]         a_wdata;
  logic                b_valid, b_ready;
  logic [REG_ADDR_R:0] b_rd;
  logic [XL:0]         b_wdata;
  logic                sb_set;
  logic [REG_ADDR_R:0] sb_rd;
  logic [REG_ADDR_R:0] q_rs1, q_rs2, q_rd;
  logic                q_hazard;
  logic                rf_wen;
  logic [REG_ADDR_R:0] rf_addr;
  logic [XL:0]         rf_wdata;

  core_regfile_wbarb #(.STARVE_LIMIT(LIMIT), .STARVE_W(2)) dut (
    .g_clk(g_clk), .g_resetn(g_resetn),
    .a_valid(a_valid), .a_ready(a_ready), .a_rd(a_rd), .a_wdata(a_wdata),
    .b_valid(b_valid), .b_ready(b_ready), .b_rd(b_rd), .b_wdata(b_wdata),
    .sb_set(sb_set), .sb_rd(sb_rd),
    .q_rs1(q_rs1), .q_rs2(q_rs2), .q_rd(q_rd), .q_hazard(q_hazard),
    .rf_wen(rf_wen), .rf_addr(rf_addr), .rf_wdata(rf_wdata)
  );

  initial g_clk = 1'b0;
  always #5 g_clk = ~g_clk;

  // Reference model: set of outstanding long-op destinations, how long B has
  // been waiting, and the write expected on the register-file port.
  bit          pend [32];
  int          waited;
  bit          m_wen;
  logic [4:0]  m_addr;
  logic [31:0] m_data;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    foreach (pend[i]) pend[i] = 1'b0;
    waited = 0;
    m_wen  = 1'b0;
    m_addr = '0;
    m_data = '0;
  endfunction

  function automatic bit model_hazard();
    bit h;
    h = (q_rs1 != 0 && pend[q_rs1]) || (q_rs2 != 0 && pend[q_rs2]) || (q_rd != 0 && pend[q_rd]);
    if (m_wen && m_addr != 0 && (m_addr == q_rs1 || m_addr == q_rs2)) h = 1'b1;
    return h;
  endfunction

  // One clock cycle with the inputs currently driven: check handshakes and
  // hazard mid-cycle, advance the model at the edge, then check the write.
  task automatic tick(input string tag);
    bit starved, ar, br, acc_a, acc_b;
    @(negedge g_clk);
    starved = (waited >= LIMIT);
    ar = starved ? !b_valid : 1'b1;
    br = starved ? 1'b1 : !a_valid;
    check({tag, ".a_ready"}, 64'(a_ready), 64'(ar));
    check({tag, ".b_ready"}, 64'(b_ready), 64'(br));
    check({tag, ".q_hazard"}, 64'(q_hazard), 64'(model_hazard()));
    acc_a = a_valid && ar;
    acc_b = b_valid && br;
    @(posedge g_clk);
    if (acc_b) pend[b_rd] = 1'b0;
    if (sb_set && sb_rd != 0) pend[sb_rd] = 1'b1;
    waited = (b_valid && !br) ? ((waited < LIMIT) ? waited + 1 : LIMIT) : 0;
    if (acc_a) begin
      m_wen = (a_rd != 0); m_addr = a_rd; m_data = a_wdata;
    end else if (acc_b) begin
      m_wen = (b_rd != 0); m_addr = b_rd; m_data = b_wdata;
    end else begin
      m_wen = 1'b0;
    end
    #1;
    check({tag, ".rf_wen"}, 64'(rf_wen), 64'(m_wen));
    if (m_wen) begin
      check({tag, ".rf_addr"}, 64'(rf_addr), 64'(m_addr));
      check({tag, ".rf_wdata"}, 64'(rf_wdata), 64'(m_data));
    end
  endtask

  task automatic peek_hazard(input string tag, input bit exp);
    #1;
    check(tag, 64'(q_hazard), 64'(exp));
  endtask

  task automatic idle();
    a_valid = 0; b_valid = 0; sb_set = 0;
    a_rd = '0; b_rd = '0; sb_rd = '0;
    a_wdata = '0; b_wdata = '0;
    q_rs1 = '0; q_rs2 = '0; q_rd = '0;
  endtask

  initial begin
    logic [4:0] seq [4];
    seq = '{5'd3, 5'd3, 5'd3, 5'd7};
    idle();
    model_reset();

    // Reset held with a write request pending: nothing may reach the port.
    g_resetn = 0;
    a_valid = 1; a_rd = 5'd5; a_wdata = 32'hAA; q_rs1 = 5'd5;
    repeat (2) @(posedge g_clk);
    @(negedge g_clk);
    check("reset.rf_wen", 64'(rf_wen), 64'd0);
    check("reset.q_hazard", 64'(q_hazard), 64'd0);
    check("reset.rf_addr", 64'(rf_addr), 64'd0);
    a_valid = 0;
    g_resetn = 1;
    @(posedge g_clk); #1;

    // First write after reset appears one cycle after acceptance.
    a_valid = 1; a_rd = 5'd5; a_wdata = 32'hAA; q_rs1 = 5'd0;
    tick("first_write");
    check("first_write.addr5", 64'(rf_addr), 64'd5);
    check("first_write.dataAA", 64'(rf_wdata), 64'hAA);

    // Both sources valid: A wins three times, then starved B wins.
    a_valid = 1; a_rd = 5'd3; a_wdata = 32'h1111_0003;
    b_valid = 1; b_rd = 5'd7; b_wdata = 32'h2222_0007;
    for (int i = 0; i < 4; i++) begin
      tick("starve");
      check("starve.addr_seq", 64'(rf_addr), 64'(seq[i]));
    end
    tick("starve_after");
    check("starve_after.a_wins", 64'(rf_addr), 64'd3);
    idle();
    tick("idle0");

    // Scoreboard: pending rd=9 stalls until B's write has landed.
    sb_set = 1; sb_rd = 5'd9;
    tick("sb_set9");
    sb_set = 0; q_rs2 = 5'd9;
    peek_hazard("sb9.pending", 1'b1);
    b_valid = 1; b_rd = 5'd9; b_wdata = 32'hDEAD_0009;
    tick("sb9.complete");
    b_valid = 0;
    peek_hazard("sb9.rf_wen_cycle", 1'b1);
    tick("sb9.drain");
    peek_hazard("sb9.cleared", 1'b0);

    // Set and clear of the same register in one cycle: set wins.
    idle();
    sb_set = 1; sb_rd = 5'd4;
    b_valid = 1; b_rd = 5'd4; b_wdata = 32'h0000_4444;
    tick("collide");
    idle(); q_rd = 5'd4;
    peek_hazard("collide.still_set", 1'b1);
    tick("collide.hold");

    // x0: handshake completes, no write, never pending.
    idle();
    a_valid = 1; a_rd = 5'd0; a_wdata = 32'hFFFF_FFFF;
    #1 check("x0.a_ready", 64'(a_ready), 64'd1);
    tick("x0.write");
    check("x0.no_wen", 64'(rf_wen), 64'd0);
    idle();
    sb_set = 1; sb_rd = 5'd0;
    tick("x0.sb_set");
    idle();
    peek_hazard("x0.no_hazard", 1'b0);

    // Random traffic over a small register range to provoke collisions.
    for (int n = 0; n < 400; n++) begin
      a_valid = ($urandom_range(0, 3) != 0);
      b_valid = ($urandom_range(0, 2) != 0);
      a_rd    = 5'($urandom_range(0, 7));
      b_rd    = 5'($urandom_range(0, 7));
      a_wdata = $urandom;
      b_wdata = $urandom;
      sb_set  = ($urandom_range(0, 3) == 0);
      sb_rd   = 5'($urandom_range(0, 7));
      q_rs1   = 5'($urandom_range(0, 7));
      q_rs2   = 5'($urandom_range(0, 7));
      q_rd    = 5'($urandom_range(0, 7));
      tick("rand");
    end

    // Reset during the rf_wen cycle drops the write and the scoreboard.
    idle();
    sb_set = 1; sb_rd = 5'd12;
    tick("mid.sb12");
    idle();
    a_valid = 1; a_rd = 5'd6; a_wdata = 32'h0606_0606;
    tick("mid.write");
    a_valid = 0;
    #1 g_resetn = 0;
    #1 check("mid.rf_wen_drop", 64'(rf_wen), 64'd0);
    model_reset();
    #20 g_resetn = 1;
    @(posedge g_clk); #1;
    q_rs1 = 5'd12;
    peek_hazard("mid.sb_cleared", 1'b0);
    tick("mid.after");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/core_regfile_wbarb.md
Name: core_regfile_wbarb

Overview:
- Write-port scheduler for the 2-read/1-write core register file.
- Shares the single write port between two sources:
  - Port A: in-order pipeline writeback. Normal priority.
  - Port B: long-latency unit result (mul/div/load return).
- Holds a pending-destination scoreboard so issue logic can detect RAW/WAW hazards against outstanding port B results.
- Drives the register file rd_wen/rd_addr/rd_wdata from a registered output stage.

Parameters:
- XL, from core_common.svh: data MSB index (XLEN-1).
- REG_ADDR_R, 4, from core_common.svh: register address MSB.
- STARVE_LIMIT, 3: cycles port B may wait before it takes priority over A.
- STARVE_W, 2: width of the starvation counter. Must satisfy 2^STARVE_W > STARVE_LIMIT.

Ports:
- g_clk  in  1  core clock
- g_resetn  in  1  asynchronous active-low reset
- a_valid  in  1  pipeline writeback valid
- a_ready  out  1  pipeline writeback accepted; low stalls writeback
- a_rd  in  REG_ADDR_R+1  destination register
- a_wdata  in  XL+1  write data
- b_valid  in  1  long-op result valid
- b_ready  out  1  long-op result accepted
- b_rd  in  REG_ADDR_R+1  destination register
- b_wdata  in  XL+1  write data
- sb_set  in  1  long-op issued this cycle; mark sb_rd pending
- sb_rd  in  REG_ADDR_R+1  long-op destination
- q_rs1  in  REG_ADDR_R+1  issuing instruction rs1
- q_rs2  in  REG_ADDR_R+1  issuing instruction rs2
- q_rd  in  REG_ADDR_R+1  issuing instruction rd
- q_hazard  out  1  combinational: issue must stall
- rf_wen  out  1  register file write enable
- rf_addr  out  REG_ADDR_R+1  register file write address
- rf_wdata  out  XL+1  register file write data

Behaviour:
- Reset: all flops clear asynchronously on g_resetn low; no write is in flight after reset.
  - rf_wen=0, rf_addr=0, rf_wdata=0.
  - Scoreboard = 0. Starvation counter = 0.
- Arbitration (combinational, per cycle):
  - Default: A has priority. a_ready = 1; b_ready = !a_valid.
  - Starved (cnt == STARVE_LIMIT): B has priority. b_ready = 1; a_ready = !b_valid.
- Acceptance:
  - At most one accept per cycle, winner = the source with valid && ready.
  - Accepted rd/wdata are registered into rf_* at the next edge. Write latency: accept at edge N → rf_wen high in cycle N+1 → regfile updated at edge N+1.
  - rf_wen = 0 in any cycle following no accept.
  - Accept with rd == 0: still accepted (handshake completes), but rf_wen stays 0.
- Starvation counter:
  - Increments when b_valid && !b_ready. Saturates at STARVE_LIMIT.
  - Cleared on B accept, and when b_valid is low.
- Scoreboard (31 bits, x1..x31; x0 never pending):
  - sb_set with sb_rd != 0 sets bit sb_rd at the edge.
  - B accept clears bit b_rd at the edge.
  - Same register set and cleared in the same cycle: set wins.
  - B completing a register whose bit is clear: no error; the write still proceeds.
- q_hazard = 1 if any of:
  - Scoreboard bit set for q_rs1, q_rs2 or q_rd (x0 excluded).
  - rf_wen && rf_addr != 0 && rf_addr equals q_rs1 or q_rs2. No bypass; the write is not yet visible.
- Combinational paths: no path from a_valid/b_valid to q_hazard.
- Reset mid-operation: a pending rf_* write is dropped. The scoreboard is lost; the core flushes long-op units on reset.

Decomposition:
- XL, REG_ADDR_R and the x0 constant come from the shared core_common.svh.
- STARVE_LIMIT default goes there too, so the core top can override it.
- One natural sub-module: core_regfile_sb (scoreboard flops plus the 3-way hazard lookup), reusable for a future second write port.
- Arbiter, starvation counter and output register stay in core_regfile_wbarb.

Test Plan:
- Reset: hold g_resetn low, drive a_valid=1 → rf_wen=0, q_hazard=0. Release reset; a_valid=1, a_rd=5, a_wdata=0xAA → next cycle rf_wen=1, rf_addr=5, rf_wdata=0xAA.
- Simultaneous requests: a_valid=b_valid=1 every cycle, a_rd=3, b_rd=7.
  - A is accepted for 3 cycles, then b_ready=1 and a_ready=0 on the 4th cycle.
  - rf_addr sequence: 3,3,3,7. Counter returns to 0.
- Scoreboard: sb_set rd=9 → q_rs2=9 gives q_hazard=1. B completes rd=9 → q_hazard=1 during the rf_wen cycle, then 0 the cycle after.
- Set/clear collision: sb_set rd=4 and B accept rd=4 in the same cycle → bit 4 remains set; q_rd=4 gives hazard=1.
- x0 handling: a_rd=0 accepted → a_ready=1, rf_wen stays 0. sb_set rd=0 → q_rs1=0 gives hazard=0.
- Async reset mid-write: assert g_resetn low during the rf_wen=1 cycle → rf_wen drops immediately; scoreboard reads all clear after release.
